// File: rtl/apb_rtl_pkg.sv
// Shared types and helpers for the APB register-bank completer.
// Holds the transfer FSM encoding and data-width derived constants.
package apb_rtl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_t;

    localparam int WAIT_CNT_W = 4;

    function automatic int strb_w(input int data_width);
        return data_width / 8;
    endfunction

    // log2 of the number of bytes in one data word (8/16/32-bit buses only)
    function automatic int addr_lsb(input int data_width);
        return (data_width == 32) ? 2 : ((data_width == 16) ? 1 : 0);
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable 4-bit down-counter that paces the APB access-phase wait states.
// done flags the last wait cycle (count of one) so the FSM can leave WAIT.
module apb_wait_counter
    import apb_rtl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  en,
    output logic                  done
);

    logic [WAIT_CNT_W-1:0] cnt_reg;
    logic [WAIT_CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign done = (cnt_reg == WAIT_CNT_W'(1));

endmodule

// File: rtl/apb_regbank_completer.sv
// APB4 completer fronting NUM_REGS software registers with wait states,
// byte strobes, read-only masking and PSLVERR; exports contents and write pulses.
module apb_regbank_completer
    import apb_rtl_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 12,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     NUM_REGS    = 8,
    parameter int                     WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VAL   = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic                           PREADY,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = strb_w(DATA_WIDTH);
    localparam int LSB    = addr_lsb(DATA_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_t state_reg;
    apb_state_t state_next;

    logic                   setup;
    logic [IDX_W-1:0]       setup_idx;
    logic [SEL_W-1:0]       setup_sel;
    logic                   offset_err;
    logic                   range_err;
    logic                   ro_hit;
    logic                   setup_err;

    logic [SEL_W-1:0]       sel_reg;
    logic                   write_reg;
    logic                   err_reg;
    logic                   pready_reg;
    logic [DATA_WIDTH-1:0]  prdata_reg;
    logic                   pslverr_reg;

    logic [SEL_W-1:0]       acc_sel;
    logic                   acc_err;
    logic                   acc_write;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic                   commit;
    logic                   cnt_load;
    logic                   cnt_en;
    logic                   cnt_done;
    logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat;

    // ---------------- Setup-phase decode ----------------
    assign setup     = PSEL && !PENABLE;
    assign setup_idx = PADDR[ADDR_WIDTH-1:LSB];
    assign setup_sel = setup_idx[SEL_W-1:0];
    assign range_err = (32'(setup_idx) >= 32'(NUM_REGS));

    generate
        if (LSB > 0) begin : g_offset
            assign offset_err = |PADDR[LSB-1:0];
        end else begin : g_no_offset
            assign offset_err = 1'b0;
        end
    endgenerate

    always_comb begin
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((32'(setup_idx) == 32'(i)) && RO_MASK[i]) begin
                ro_hit = 1'b1;
            end
        end
    end

    assign setup_err = range_err || offset_err || (PWRITE && ro_hit);

    // ---------------- Wait-state counter ----------------
    apb_wait_counter u_wait_counter (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (cnt_load),
        .load_val (WAIT_CNT_W'(WAIT_STATES)),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    // ---------------- Transfer FSM ----------------
    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (setup) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_load   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Dropping PSEL mid-access abandons the transfer silently
                if (!PSEL) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_done) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // With zero wait states DONE is entered straight from setup, before the latch exists
    assign acc_sel   = (state_reg == ST_IDLE) ? setup_sel : sel_reg;
    assign acc_err   = (state_reg == ST_IDLE) ? setup_err : err_reg;
    assign acc_write = (state_reg == ST_IDLE) ? PWRITE    : write_reg;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (acc_sel == SEL_W'(i)) begin
                rd_word = reg_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            write_reg   <= 1'b0;
            err_reg     <= 1'b0;
            pready_reg  <= 1'b0;
            prdata_reg  <= '0;
            pslverr_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pready_reg <= (state_next == ST_DONE);
            if ((state_reg == ST_IDLE) && setup) begin
                sel_reg   <= setup_sel;
                write_reg <= PWRITE;
                err_reg   <= setup_err;
            end
            if (state_next == ST_DONE) begin
                prdata_reg  <= (acc_err || acc_write) ? '0 : rd_word;
                pslverr_reg <= acc_err;
            end
        end
    end

    assign PREADY  = pready_reg;
    assign PRDATA  = prdata_reg;
    assign PSLVERR = pslverr_reg;

    // ---------------- Register array with byte-strobe merge ----------------
    assign commit = (state_reg == ST_DONE) && write_reg && !err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] q_reg;
            logic                  pulse_reg;
            logic                  hit;

            assign hit = commit && (sel_reg == SEL_W'(gi));

            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    q_reg     <= RESET_VAL;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= hit;
                    if (hit) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (PSTRB[b]) begin
                                q_reg[b*8 +: 8] <= PWDATA[b*8 +: 8];
                            end
                        end
                    end
                end
            end

            assign reg_flat[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
            assign wr_pulse[gi] = pulse_reg;
        end
    endgenerate

    assign reg_q = reg_flat;

endmodule
